mdu: RTL and testbench

Parametrised iterative multiply/divide unit for the RV32M/RV64M datapath. It is the successor to the multiply-only unit in the integer-function area. It executes all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at configurable width with a start/done handshake, and it adds a busy flag, flush, and single-edge early-out for divide special cases. It sits beside the ALU and is driven by the control unit, which stalls issue while `busy` is high.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_iter.sv | 40 ++++
 rtl/mdu.sv | 152 +++++++++++++++
 tb/tb_mdu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - funct3 op codes for the eight M-extension ops
//   - FSM state encoding
//   - operand signedness / op-class helpers
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one combinational iteration of the multiply/divide datapath.
//   acc_i  : 2*XLEN accumulator. mul: {partial product hi, remaining multiplier}
//                                div: {partial remainder, remaining dividend/quotient}
//   opnd_i : magnitude added (mul, multiplicand) or subtracted (div, divisor)
//   div_i  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_o  : accumulator after this step
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;

  always_comb begin
    hi     = acc_i[2*XLEN-1:XLEN];
    lo     = acc_i[XLEN-1:0];
    // Multiply: add multiplicand when the current multiplier bit is set,
    // keep the carry and shift the whole accumulator right by one.
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder. The remainder
    // stays below the divisor, so the difference always fits in XLEN bits.
    rem_sh = {hi, lo[XLEN-1]};
    diff   = rem_sh[XLEN-1:0] - opnd_i;
    if (div_i) begin
      if (rem_sh >= {1'b0, opnd_i}) acc_o = {diff, lo[XLEN-2:0], 1'b1};
      else                          acc_o = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
//   clk, rst_n   : rising-edge clock, async active-low reset
//   start, op    : request and funct3; a/b sampled only on an accepted start
//   flush        : synchronous abort, wins over start
//   busy         : op accepted and still iterating (RUN/FIX)
//   done, res    : one-cycle completion pulse; res held until the next result
//
// state  | meaning
// IDLE   | waiting for a request
// RUN    | iterating, one bit per cycle, XLEN cycles
// FIX    | sign correction and result select
// DONE   | result presented (done=1), may accept the next start
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int             CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic [2*XLEN-1:0] acc_next;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              b_zero, ovf;
  logic [XLEN-1:0]   early_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_res;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div(op_q)),
    .acc_o  (acc_next)
  );

  always_comb begin
    a_neg  = a_signed(op) & a[XLEN-1];
    b_neg  = b_signed(op) & b[XLEN-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
             (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // op[1] selects remainder within the divide group
    if (b_zero) early_res = op[1] ? a : '1;
    else        early_res = op[1] ? '0 : a;

    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    if (is_div(op_q)) begin
      if (op_q[1]) fix_res = rneg_q ? -rem : rem;
      else         fix_res = neg_q  ? -quo : quo;
    end else begin
      fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_d   = op;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            cnt_d  = '0;
            if (is_div(op) && (b_zero || ovf)) begin
              state_d = S_DONE;
              res_d   = early_res;
            end else begin
              state_d = S_RUN;
              acc_d   = {{XLEN{1'b0}}, is_div(op) ? a_mag : b_mag};
              opnd_d  = is_div(op) ? b_mag : a_mag;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          acc_d = acc_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
        S_FIX: begin
          res_d   = fix_res;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign res  = res_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n32, rst_n16;
  logic        start32, flush32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        start16, flush16, busy16, done16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, res16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdu #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n32), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busy32), .done(done32), .res(res32)
  );

  mdu #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n16), .start(start16), .op(op16), .a(a16), .b(b16),
    .flush(flush16), .busy(busy16), .done(done16), .res(res16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives a request, returns 1 ns after the accept edge T0.
  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom;
  endtask

  // lat = k where done is first seen after edge T0+k; -1 on timeout.
  task automatic wait_done32(output int lat, output logic busy_seen);
    lat = -1; busy_seen = 1'b0;
    for (int n = 0; n <= 80; n++) begin
      if (done32) begin lat = n; break; end
      busy_seen = busy_seen | busy32;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        bs;
    logic        seen;
    logic [31:0] held;

    vecs[0]  = '{OP_MUL,    32'hFFFFFFFD, 32'hFFFFFFFC, 32'h0000000C, 33};
    vecs[1]  = '{OP_MULH,   32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 33};
    vecs[2]  = '{OP_MULHSU, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFD, 33};
    vecs[3]  = '{OP_MULHU,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFF9, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[6]  = '{OP_DIVU,   32'h00000007, 32'h00000002, 32'h00000003, 33};
    vecs[7]  = '{OP_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, 0};
    vecs[8]  = '{OP_REMU,   32'h00000007, 32'h00000000, 32'h00000007, 0};
    vecs[9]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[10] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
    vecs[11] = '{OP_DIV,    32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[12] = '{OP_REM,    32'h00000064, 32'hFFFFFFF9, 32'h00000002, 33};
    vecs[13] = '{OP_REM,    32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 33};
    vecs[14] = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[15] = '{OP_MUL,    32'h00010001, 32'h00010001, 32'h00020001, 33};
    vecs[16] = '{OP_DIV,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 0};
    vecs[17] = '{OP_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 0};
    vecs[18] = '{OP_DIVU,   32'hFFFFFFFF, 32'h80000001, 32'h00000001, 33};
    vecs[19] = '{OP_REMU,   32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33};

    rst_n32 = 1'b0; rst_n16 = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start16 = 1'b0; flush16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy32", 64'(busy32), 64'd0);
    check("rst done32", 64'(done32), 64'd0);
    check("rst res32",  64'(res32),  64'd0);
    check("rst busy16", 64'(busy16), 64'd0);
    check("rst res16",  64'(res16),  64'd0);
    rst_n32 = 1'b1; rst_n16 = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      issue32(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done32(lat, bs);
      check($sformatf("vec%0d res", i), 64'(res32), 64'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d busy during op", i), 64'(bs), (vecs[i].lat == 0) ? 64'd0 : 64'd1);
      check($sformatf("vec%0d busy at done", i), 64'(busy32), 64'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d done width", i), 64'(done32), 64'd0);
      check($sformatf("vec%0d res hold", i), 64'(res32), 64'(vecs[i].exp));
    end

    // Back-to-back: second start issued in the DONE cycle of the first.
    issue32(OP_MUL, 32'd5, 32'd6);
    wait_done32(lat, bs);
    check("b2b first res", 64'(res32), 64'd30);
    issue32(OP_MUL, 32'd16, 32'd48);
    check("b2b busy at accept", 64'(busy32), 64'd1);
    check("b2b done drops", 64'(done32), 64'd0);
    check("b2b res held while running", 64'(res32), 64'd30);
    wait_done32(lat, bs);
    check("b2b res", 64'(res32), 64'd768);
    check("b2b latency", 64'(lat), 64'd33);

    // Flush at edge T0+10.
    @(posedge clk); #1;
    issue32(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("flush pre busy", 64'(busy32), 64'd1);
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    check("flush busy", 64'(busy32), 64'd0);
    check("flush done", 64'(done32), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done32 | busy32;
    end
    check("flush no done", 64'(seen), 64'd0);
    check("flush res unchanged", 64'(res32), 64'd768);

    // start and flush together: start dropped.
    op32 = OP_MUL; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1; flush32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; flush32 = 1'b0;
    check("start+flush busy", 64'(busy32), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done32 | busy32;
    end
    check("start+flush no done", 64'(seen), 64'd0);
    check("start+flush res unchanged", 64'(res32), 64'd768);

    issue32(OP_MUL, 32'd2, 32'd3);
    wait_done32(lat, bs);
    check("post flush res", 64'(res32), 64'd6);
    check("post flush latency", 64'(lat), 64'd33);

    // XLEN=16 instance.
    op16 = OP_MULHU; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'h1234; b16 = 16'h0;
    lat = -1;
    for (int n = 0; n <= 40; n++) begin
      if (done16) begin lat = n; break; end
      @(posedge clk); #1;
    end
    check("x16 mulhu res", 64'(res16), 64'h0000FFFE);
    check("x16 mulhu latency", 64'(lat), 64'd17);
    @(posedge clk); #1;
    held = 32'(res16);
    check("x16 res hold", 64'(held), 64'h0000FFFE);

    // Asynchronous reset in the middle of RUN.
    op16 = OP_MUL; a16 = 16'd3; b16 = 16'd5; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("x16 busy before reset", 64'(busy16), 64'd1);
    rst_n16 = 1'b0;
    #1;
    check("x16 async rst busy", 64'(busy16), 64'd0);
    check("x16 async rst done", 64'(done16), 64'd0);
    check("x16 async rst res",  64'(res16),  64'd0);
    @(posedge clk); #1;
    rst_n16 = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      seen = seen | done16 | busy16;
    end
    check("x16 op lost after reset", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
